// File: rtl/scu_dsp_dma_ctl_if.sv
// Signal bundle between the SCU DSP DMA controller, the DSP core and the A/B-bus arbiter.
// The controller uses the master view; the DSP core and the bus side use the slave view.
interface scu_dsp_dma_ctl_if #(
  parameter int unsigned ADDR_W = 27
);
  // DSP DSO bus and register strobes
  logic [31:0]       dso;
  logic              ra0w;
  logic              wa0w;
  logic              dmaw;

  // DSP word handshake
  logic              dma_req;
  logic              dma_we;
  logic              dma_last;
  logic [31:0]       dma_do;
  logic [31:0]       dma_di;
  logic              dma_ack;
  logic              dma_end;

  // External bus master port
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_a;
  logic [31:0]       bus_do;
  logic [31:0]       bus_di;
  logic              bus_ack;

  // Status
  logic              busy;
  logic              err;

  modport master (
    input  dso, ra0w, wa0w, dmaw,
    input  dma_req, dma_we, dma_last, dma_do,
    output dma_di, dma_ack, dma_end,
    output bus_req, bus_we, bus_a, bus_do,
    input  bus_di, bus_ack,
    output busy, err
  );

  modport slave (
    output dso, ra0w, wa0w, dmaw,
    output dma_req, dma_we, dma_last, dma_do,
    input  dma_di, dma_ack, dma_end,
    input  bus_req, bus_we, bus_a, bus_do,
    output bus_di, bus_ack,
    input  busy, err
  );
endinterface

// File: rtl/scu_dsp_dma_ctl.sv
// SCU DSP DMA channel sequencer: latches addresses and the DMA command from DSO, then moves
// one word per DMA_REQ/DMA_ACK handshake between DSP RAM and the external bus master port.
module scu_dsp_dma_ctl #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce_r,
  scu_dsp_dma_ctl_if.master io_dma
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_ACK  = 3'd4,
    S_END  = 3'd5,
    S_ENDW = 3'd6
  } state_t;

  // Counter value on whose next unanswered CE_R cycle the access is abandoned.
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_ra;
  logic [ADDR_W-1:0]  r_wa;
  logic [ADDR_W-1:0]  r_bus_a;
  logic [2:0]         r_add;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_ack_pend;
  logic [31:0]        r_di_pend;
  logic               r_err;
  logic [31:0]        r_dma_di;
  logic [31:0]        r_bus_do;

  logic               r_bus_req;
  logic               r_bus_we;
  logic               r_dma_ack;
  logic               r_dma_end;
  logic               r_busy;

  logic               w_in_bus;
  logic               w_ack;
  logic               w_tmo_hit;
  logic [ADDR_W-1:0]  w_addr_ld;
  logic [ADDR_W-1:0]  w_inc_rd;
  logic [ADDR_W-1:0]  w_inc_wr;

  logic               w_bus_req_d;
  logic               w_bus_we_d;
  logic               w_dma_ack_d;
  logic               w_dma_end_d;
  logic               w_busy_d;

  logic               w_unused;

  assign w_in_bus  = (r_state == S_RD) || (r_state == S_WR);
  // A BUS_ACK seen between CE_R cycles is held in r_ack_pend until the next CE_R.
  assign w_ack     = io_dma.bus_ack | r_ack_pend;
  assign w_tmo_hit = w_in_bus && !w_ack && (r_tmo == TMO_LAST);
  assign w_addr_ld = ADDR_W'({io_dma.dso[24:0], 2'b00});
  assign w_unused  = &{1'b0, io_dma.dso[31:25]};

  // Read stride is one word; write stride doubles per ADD step starting at 4 bytes.
  assign w_inc_rd = (r_add == 3'd0) ? '0 : ADDR_W'(4);
  assign w_inc_wr = (r_add == 3'd0) ? '0 : (ADDR_W'(1) << (4'(r_add) + 4'd1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (i_ce_r) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (io_dma.dmaw) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (io_dma.dma_req) begin
          w_state_nxt = io_dma.dma_we ? S_WR : S_RD;
        end
      end
      S_RD, S_WR: begin
        if (w_ack) begin
          w_state_nxt = S_ACK;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_END;
        end
      end
      S_ACK: begin
        w_state_nxt = io_dma.dma_last ? S_END : S_ARM;
      end
      S_END: begin
        w_state_nxt = S_ENDW;
      end
      S_ENDW: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered, so registered outputs line up with the state
  always_comb begin
    w_bus_req_d = 1'b0;
    w_bus_we_d  = 1'b0;
    w_dma_ack_d = 1'b0;
    w_dma_end_d = 1'b0;
    w_busy_d    = 1'b1;
    unique case (w_state_nxt)
      S_IDLE: w_busy_d    = 1'b0;
      S_RD:   w_bus_req_d = 1'b1;
      S_WR: begin
        w_bus_req_d = 1'b1;
        w_bus_we_d  = 1'b1;
      end
      S_ACK:  w_dma_ack_d = 1'b1;
      S_END:  w_dma_end_d = 1'b1;
      default: begin
        w_busy_d = 1'b1;
      end
    endcase
  end

  // Control outputs; BUS_REQ is released as soon as the bus answers, even between CE_R cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_req <= 1'b0;
      r_bus_we  <= 1'b0;
      r_dma_ack <= 1'b0;
      r_dma_end <= 1'b0;
      r_busy    <= 1'b0;
    end else if (i_ce_r) begin
      r_bus_req <= w_bus_req_d;
      r_bus_we  <= w_bus_we_d;
      r_dma_ack <= w_dma_ack_d;
      r_dma_end <= w_dma_end_d;
      r_busy    <= w_busy_d;
    end else if (io_dma.bus_ack) begin
      r_bus_req <= 1'b0;
    end
  end

  // Address registers, command latch, timeout counter and data capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ra       <= '0;
      r_wa       <= '0;
      r_bus_a    <= '0;
      r_add      <= '0;
      r_tmo      <= '0;
      r_ack_pend <= 1'b0;
      r_di_pend  <= '0;
      r_err      <= 1'b0;
      r_dma_di   <= '0;
      r_bus_do   <= '0;
    end else if (i_ce_r) begin
      r_ack_pend <= 1'b0;

      // A DSO load takes priority over the per-word step on the same cycle.
      if (io_dma.ra0w) begin
        r_ra <= w_addr_ld;
      end else if ((r_state == S_RD) && w_ack) begin
        r_ra <= r_ra + w_inc_rd;
      end

      if (io_dma.wa0w) begin
        r_wa <= w_addr_ld;
      end else if ((r_state == S_WR) && w_ack) begin
        r_wa <= r_wa + w_inc_wr;
      end

      if ((r_state == S_IDLE) && io_dma.dmaw) begin
        r_add <= io_dma.dso[17:15];
        r_err <= 1'b0;
      end else if (w_tmo_hit) begin
        r_err <= 1'b1;
      end

      r_tmo <= (w_in_bus && !w_ack) ? (r_tmo + TMO_W'(1)) : '0;

      if ((r_state == S_RD) && w_ack) begin
        r_dma_di <= r_ack_pend ? r_di_pend : io_dma.bus_di;
      end

      if ((r_state == S_ARM) && io_dma.dma_req) begin
        r_bus_a <= io_dma.dma_we ? r_wa : r_ra;
        if (io_dma.dma_we) begin
          r_bus_do <= io_dma.dma_do;
        end
      end
    end else if (w_in_bus && io_dma.bus_ack) begin
      r_ack_pend <= 1'b1;
      r_di_pend  <= io_dma.bus_di;
    end
  end

  assign io_dma.dma_di  = r_dma_di;
  assign io_dma.dma_ack = r_dma_ack;
  assign io_dma.dma_end = r_dma_end;
  assign io_dma.bus_req = r_bus_req;
  assign io_dma.bus_we  = r_bus_we;
  assign io_dma.bus_a   = r_bus_a;
  assign io_dma.bus_do  = r_bus_do;
  assign io_dma.busy    = r_busy;
  assign io_dma.err     = r_err;

endmodule

// File: tb/tb_scu_dsp_dma_ctl.sv
// Randomized bench for scu_dsp_dma_ctl: a DSP-side driver and a bus responder, checked against
// an address/data model derived from the transfer rules (base, stride table, modulo wrap).
module tb_scu_dsp_dma_ctl;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned TMO_W  = 8;
  localparam longint      AMASK  = (longint'(1) << ADDR_W) - 1;
  localparam int          TMO_CYC = (1 << TMO_W) - 1;

  typedef struct {
    bit          we;
    longint      addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  logic clk  = 1'b1;
  logic rst  = 1'b1;
  logic ce_r = 1'b1;
  int   ce_div = 1;
  int   ce_ph  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  longint m_ra = 0;
  longint m_wa = 0;
  int     wr_inc_tbl [8] = '{0, 4, 8, 16, 32, 64, 128, 256};

  // Bus responder state
  acc_t acc_q [$];
  bit   bus_hold = 1'b0;
  int   bus_wait = 0;

  // Event monitor counters
  int   ack_cnt = 0;
  int   end_cnt = 0;
  int   req_ce_cnt = 0;
  logic ack_q = 1'b0;
  logic end_q = 1'b0;

  scu_dsp_dma_ctl_if #(.ADDR_W(ADDR_W)) u_if ();

  scu_dsp_dma_ctl #(.ADDR_W(ADDR_W), .TMO_W(TMO_W)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ce_r (ce_r),
    .io_dma (u_if.master)
  );

  always #5 clk = ~clk;

  // CE_R strobe: high one clock in every ce_div, updated well away from the rising edge
  always @(posedge clk) begin
    #2;
    ce_ph = (ce_ph + 1) % ce_div;
    ce_r  = (ce_ph == 0);
  end

  // Bus responder: random wait, one-clock BUS_ACK with random read data, logs every access
  always @(negedge clk) begin : p_bus
    acc_t a;
    u_if.bus_ack = 1'b0;
    if (u_if.bus_req && !bus_hold && !rst) begin
      if (bus_wait > 0) begin
        bus_wait--;
      end else begin
        a.we    = u_if.bus_we;
        a.addr  = longint'(u_if.bus_a);
        a.wdata = u_if.bus_do;
        a.rdata = $urandom;
        u_if.bus_di  = a.rdata;
        u_if.bus_ack = 1'b1;
        acc_q.push_back(a);
        bus_wait = $urandom_range(0, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (u_if.dma_ack && !ack_q) ack_cnt++;
    if (u_if.dma_end && !end_q) end_cnt++;
    if (u_if.bus_req && ce_r) req_ce_cnt++;
    ack_q = u_if.dma_ack;
    end_q = u_if.dma_end;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at a falling edge whose following rising edge carries CE_R.
  task automatic wait_ce();
    do @(negedge clk); while (!ce_r);
  endtask

  task automatic strobe(input bit ra, input bit wa, input bit dm, input logic [31:0] d);
    wait_ce();
    u_if.dso  = d;
    u_if.ra0w = ra;
    u_if.wa0w = wa;
    u_if.dmaw = dm;
    @(negedge clk);
    u_if.ra0w = 1'b0;
    u_if.wa0w = 1'b0;
    u_if.dmaw = 1'b0;
    if (ra) m_ra = ((longint'(d) & 64'h1FF_FFFF) * 4) & AMASK;
    if (wa) m_wa = ((longint'(d) & 64'h1FF_FFFF) * 4) & AMASK;
  endtask

  task automatic run_xfer(input bit we, input int add, input int n, input bit hold);
    int          a0, e0, r0, budget, len;
    bit          tmo_seen;
    logic [31:0] d, wd;
    acc_t        a;
    longint      base;

    bus_hold = hold;
    a0 = ack_cnt;
    e0 = end_cnt;
    r0 = req_ce_cnt;
    d  = $urandom;
    d[17:15] = 3'(add);
    strobe(1'b0, 1'b0, 1'b1, d);
    check_eq("err_clr_on_dmaw", 64'(u_if.err), 64'(0));

    tmo_seen = 1'b0;
    for (int k = 0; k < n && !tmo_seen; k++) begin
      wd = $urandom;
      u_if.dma_we   = we;
      u_if.dma_last = (k == n - 1);
      u_if.dma_do   = wd;
      u_if.dma_req  = 1'b1;
      budget = 0;
      while (!u_if.dma_ack && !u_if.dma_end && budget < 4000) begin
        @(negedge clk);
        budget++;
      end
      if (u_if.dma_end) begin
        tmo_seen = 1'b1;
      end else begin
        check_eq("dma_ack_seen", 64'(u_if.dma_ack), 64'(1));
        check_eq("bus_access_cnt", 64'(acc_q.size()), 64'(1));
        if (acc_q.size() > 0) begin
          a    = acc_q.pop_front();
          base = we ? m_wa : m_ra;
          check_eq("bus_a", 64'(a.addr), 64'(base));
          check_eq("bus_we", 64'(a.we), 64'(we));
          if (we) check_eq("bus_do", 64'(a.wdata), 64'(wd));
          else    check_eq("dma_di", 64'(u_if.dma_di), 64'(a.rdata));
        end
        if (we) m_wa = (m_wa + wr_inc_tbl[add]) & AMASK;
        else    m_ra = (m_ra + ((add == 0) ? 0 : 4)) & AMASK;
        len = 0;
        budget = 0;
        while (u_if.dma_ack && budget < 100) begin
          if (ce_r) len++;
          @(negedge clk);
          budget++;
        end
        check_eq("dma_ack_len", 64'(len), 64'(1));
      end
    end
    u_if.dma_req  = 1'b0;
    u_if.dma_last = 1'b0;
    check_eq("tmo_path", 64'(tmo_seen), 64'(hold));

    budget = 0;
    while (!u_if.dma_end && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_eq("dma_end_seen", 64'(u_if.dma_end), 64'(1));
    len = 0;
    while (u_if.dma_end && budget < 400) begin
      if (ce_r) len++;
      @(negedge clk);
      budget++;
    end
    check_eq("dma_end_len", 64'(len), 64'(1));
    while (u_if.busy && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    check_eq("busy_clr", 64'(u_if.busy), 64'(0));
    check_eq("dma_ack_pulses", 64'(ack_cnt - a0), 64'(hold ? 0 : n));
    check_eq("dma_end_pulses", 64'(end_cnt - e0), 64'(1));
    check_eq("err", 64'(u_if.err), 64'(hold));
    if (hold) check_eq("tmo_req_ce_cycles", 64'(req_ce_cnt - r0), 64'(TMO_CYC));
    bus_hold = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_busy"},    64'(u_if.busy),    64'(0));
    check_eq({pfx, "_bus_req"}, 64'(u_if.bus_req), 64'(0));
    check_eq({pfx, "_bus_we"},  64'(u_if.bus_we),  64'(0));
    check_eq({pfx, "_bus_a"},   64'(u_if.bus_a),   64'(0));
    check_eq({pfx, "_bus_do"},  64'(u_if.bus_do),  64'(0));
    check_eq({pfx, "_dma_di"},  64'(u_if.dma_di),  64'(0));
    check_eq({pfx, "_dma_ack"}, 64'(u_if.dma_ack), 64'(0));
    check_eq({pfx, "_dma_end"}, 64'(u_if.dma_end), 64'(0));
    check_eq({pfx, "_err"},     64'(u_if.err),     64'(0));
  endtask

  initial begin
    int budget;
    u_if.dso      = '0;
    u_if.ra0w     = 1'b0;
    u_if.wa0w     = 1'b0;
    u_if.dmaw     = 1'b0;
    u_if.dma_req  = 1'b0;
    u_if.dma_we   = 1'b0;
    u_if.dma_last = 1'b0;
    u_if.dma_do   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Read burst at 0x400, stride 4, then ADD=0 reads sit on the advanced address
    strobe(1'b0, 1'b1, 1'b0, 32'h100);
    strobe(1'b1, 1'b0, 1'b0, 32'h100);
    run_xfer(1'b0, 1, 3, 1'b0);
    run_xfer(1'b0, 0, 4, 1'b0);
    run_xfer(1'b0, 1, 1, 1'b0);

    // Write burst at 0x800 with ADD=3, then confirm WA advanced to 0x820
    strobe(1'b0, 1'b1, 1'b0, 32'h200);
    run_xfer(1'b1, 3, 2, 1'b0);
    run_xfer(1'b1, 0, 1, 1'b0);

    // Bus timeout, then a fresh command clears ERR
    run_xfer(1'b0, 1, 2, 1'b1);
    run_xfer(1'b1, 2, 2, 1'b0);

    // Address wrap at the top of the byte-address space
    strobe(1'b1, 1'b1, 1'b0, 32'h01FF_FFFF);
    run_xfer(1'b0, 1, 2, 1'b0);
    run_xfer(1'b1, 7, 2, 1'b0);

    // CE_R one clock in three, bus answers may fall between CE_R cycles
    ce_div = 3;
    run_xfer(1'b0, 1, 4, 1'b0);
    run_xfer(1'b1, 4, 3, 1'b0);

    // Reset asserted on a non-CE_R edge while a write holds BUS_REQ
    bus_hold = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, 32'h0001_8000);
    u_if.dma_we   = 1'b1;
    u_if.dma_last = 1'b0;
    u_if.dma_do   = 32'hDEAD_BEEF;
    u_if.dma_req  = 1'b1;
    budget = 0;
    while (!u_if.bus_req && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check_eq("rst_pre_bus_req", 64'(u_if.bus_req), 64'(1));
    do @(negedge clk); while (ce_r);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    u_if.dma_req = 1'b0;
    bus_hold = 1'b0;
    m_ra = 0;
    m_wa = 0;
    run_xfer(1'b0, 1, 2, 1'b0);

    // Randomized transfers
    repeat (24) begin
      ce_div = ($urandom_range(0, 1) == 1) ? 3 : 1;
      if ($urandom_range(0, 2) == 0)
        strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom);
      run_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(1, 5)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
